// File: rtl/reg_desp_pkg.sv
// Shared constants for the reg_desp family of universal shift registers.
// Imported by the RTL and by anything that drives the mode/dir inputs.
package reg_desp_pkg;

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_ASH   = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/reg_desp_n.sv
// Parametrised universal shift register: logical shift, rotate, load and arithmetic shift,
// with a registered serial output and a saturating shift counter for serdes control.
module reg_desp_n
  import reg_desp_pkg::*;
#(
  parameter int unsigned         WIDTH   = 4,
  parameter logic [WIDTH-1:0]    RST_VAL = {WIDTH{1'b0}},
  localparam int unsigned        CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             s_out_q, s_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sat;

  // done derives only from registered state, so no input reaches an output combinationally.
  assign sat = (cnt_q == CW'(WIDTH));

  always_comb begin
    q_d     = q_q;
    s_out_d = s_out_q;
    cnt_d   = cnt_q;
    if (enb) begin
      unique case (mode)
        MODE_SHIFT: begin
          if (dir == DIR_LEFT) begin
            q_d     = {q_q[WIDTH-2:0], s_in};
            s_out_d = q_q[WIDTH-1];
          end else begin
            q_d     = {s_in, q_q[WIDTH-1:1]};
            s_out_d = q_q[0];
          end
        end
        MODE_ROT: begin
          if (dir == DIR_LEFT) begin
            q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            s_out_d = q_q[WIDTH-1];
          end else begin
            q_d     = {q_q[0], q_q[WIDTH-1:1]};
            s_out_d = q_q[0];
          end
        end
        MODE_LOAD: begin
          q_d = d;
        end
        MODE_ASH: begin
          if (dir == DIR_LEFT) begin
            q_d     = {q_q[WIDTH-2:0], 1'b0};
            s_out_d = q_q[WIDTH-1];
          end else begin
            q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            s_out_d = q_q[0];
          end
        end
        default: ;
      endcase

      if (mode == MODE_LOAD) begin
        cnt_d = '0;
      end else if (!sat) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= RST_VAL;
      s_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q     = q_q;
  assign s_out = s_out_q;
  assign cnt   = cnt_q;
  assign done  = sat;

endmodule

// File: tb/tb_reg_desp_n.sv
// Bench for reg_desp_n at WIDTH=4 and WIDTH=8; expected states are queued as stimulus is
// applied and compared one cycle later.
module tb_reg_desp_n;
  import reg_desp_pkg::*;

  typedef struct {
    string      tag;
    bit         w8;
    logic [7:0] q;
    logic       s;
    logic [3:0] cnt;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset4, enb4, dir4, s_in4;
  logic [1:0] mode4;
  logic [3:0] d4, q4;
  logic       s_out4, done4;
  logic [2:0] cnt4;

  logic       reset8, enb8, dir8, s_in8;
  logic [1:0] mode8;
  logic [7:0] d8, q8;
  logic       s_out8, done8;
  logic [3:0] cnt8;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  reg_desp_n #(.WIDTH(4)) u_dut4 (
    .clk  (clk),
    .reset(reset4),
    .enb  (enb4),
    .dir  (dir4),
    .s_in (s_in4),
    .mode (mode4),
    .d    (d4),
    .q    (q4),
    .s_out(s_out4),
    .cnt  (cnt4),
    .done (done4)
  );

  reg_desp_n #(.WIDTH(8), .RST_VAL(8'h5A)) u_dut8 (
    .clk  (clk),
    .reset(reset8),
    .enb  (enb8),
    .dir  (dir8),
    .s_in (s_in8),
    .mode (mode8),
    .d    (d8),
    .q    (q8),
    .s_out(s_out8),
    .cnt  (cnt8),
    .done (done8)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instance for one edge (the other is held with enb=0) and check the result.
  task automatic step(input string tag, input bit w8, input logic rst, input logic en,
                      input logic [1:0] md, input logic dr, input logic si,
                      input logic [7:0] dd, input logic [7:0] eq, input logic es,
                      input logic [3:0] ec, input logic ed);
    exp_t e;
    if (w8) begin
      reset8 = rst; enb8 = en; mode8 = md; dir8 = dr; s_in8 = si; d8 = dd;
      reset4 = 1'b0; enb4 = 1'b0;
    end else begin
      reset4 = rst; enb4 = en; mode4 = md; dir4 = dr; s_in4 = si; d4 = dd[3:0];
      reset8 = 1'b0; enb8 = 1'b0;
    end
    sb_q.push_back('{tag, w8, eq, es, ec, ed});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.w8) begin
      check_value({e.tag, ".q"},     32'(q8),     32'(e.q));
      check_value({e.tag, ".s_out"}, 32'(s_out8), 32'(e.s));
      check_value({e.tag, ".cnt"},   32'(cnt8),   32'(e.cnt));
      check_value({e.tag, ".done"},  32'(done8),  32'(e.done));
    end else begin
      check_value({e.tag, ".q"},     32'(q4),     32'(e.q));
      check_value({e.tag, ".s_out"}, 32'(s_out4), 32'(e.s));
      check_value({e.tag, ".cnt"},   32'(cnt4),   32'(e.cnt));
      check_value({e.tag, ".done"},  32'(done4),  32'(e.done));
    end
  endtask

  initial begin
    reset4 = 1'b0; enb4 = 1'b0; dir4 = 1'b0; s_in4 = 1'b0; mode4 = MODE_SHIFT; d4 = '0;
    reset8 = 1'b0; enb8 = 1'b0; dir8 = 1'b0; s_in8 = 1'b0; mode8 = MODE_SHIFT; d8 = '0;
    @(posedge clk);
    #1;

    // WIDTH=4: reset wins over enb/LOAD
    step("rst",     0, 1, 1, MODE_LOAD,  DIR_LEFT,  0, 8'h0A, 8'h0, 0, 0, 0);
    // logical shift left with s_in=1, then right with s_in=0
    step("ld1011",  0, 0, 1, MODE_LOAD,  DIR_LEFT,  0, 8'h0B, 8'hB, 0, 0, 0);
    step("shl1",    0, 0, 1, MODE_SHIFT, DIR_LEFT,  1, 8'h00, 8'h7, 1, 1, 0);
    step("shl2",    0, 0, 1, MODE_SHIFT, DIR_LEFT,  1, 8'h00, 8'hF, 0, 2, 0);
    step("shr1",    0, 0, 1, MODE_SHIFT, DIR_RIGHT, 0, 8'h00, 8'h7, 1, 3, 0);
    // LOAD keeps s_out, clears cnt
    step("ld1001",  0, 0, 1, MODE_LOAD,  DIR_RIGHT, 0, 8'h09, 8'h9, 1, 0, 0);
    // rotate right with s_in=1 (ignored) to saturation
    step("ror1",    0, 0, 1, MODE_ROT,   DIR_RIGHT, 1, 8'h00, 8'hC, 1, 1, 0);
    step("ror2",    0, 0, 1, MODE_ROT,   DIR_RIGHT, 1, 8'h00, 8'h6, 0, 2, 0);
    step("ror3",    0, 0, 1, MODE_ROT,   DIR_RIGHT, 1, 8'h00, 8'h3, 0, 3, 0);
    step("ror4",    0, 0, 1, MODE_ROT,   DIR_RIGHT, 1, 8'h00, 8'h9, 1, 4, 1);
    step("ror5sat", 0, 0, 1, MODE_ROT,   DIR_RIGHT, 1, 8'h00, 8'hC, 1, 4, 1);
    step("ld1000",  0, 0, 1, MODE_LOAD,  DIR_RIGHT, 0, 8'h08, 8'h8, 1, 0, 0);
    // arithmetic shifts: sign fill right, zero fill left; s_in=1 ignored
    step("asr1",    0, 0, 1, MODE_ASH,   DIR_RIGHT, 1, 8'h00, 8'hC, 0, 1, 0);
    step("asr2",    0, 0, 1, MODE_ASH,   DIR_RIGHT, 1, 8'h00, 8'hE, 0, 2, 0);
    step("ld0110",  0, 0, 1, MODE_LOAD,  DIR_RIGHT, 0, 8'h06, 8'h6, 0, 0, 0);
    step("asl1",    0, 0, 1, MODE_ASH,   DIR_LEFT,  1, 8'h00, 8'hC, 0, 1, 0);
    // enb=0 ignores a LOAD
    step("hold",    0, 0, 0, MODE_LOAD,  DIR_LEFT,  1, 8'h0F, 8'hC, 0, 1, 0);
    step("rol1",    0, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h9, 1, 2, 0);
    // reset mid-sequence at cnt=2
    step("rstmid",  0, 1, 1, MODE_SHIFT, DIR_LEFT,  1, 8'h00, 8'h0, 0, 0, 0);

    // WIDTH=8 with non-zero RST_VAL
    step("rst8",    1, 1, 1, MODE_LOAD,  DIR_LEFT,  0, 8'hFF, 8'h5A, 0, 0, 0);
    step("ld81",    1, 0, 1, MODE_LOAD,  DIR_LEFT,  0, 8'h81, 8'h81, 0, 0, 0);
    step("rol8_1",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h03, 1, 1, 0);
    step("rol8_2",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h06, 0, 2, 0);
    step("rol8_3",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h0C, 0, 3, 0);
    step("rol8_4",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h18, 0, 4, 0);
    step("rol8_5",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h30, 0, 5, 0);
    step("rol8_6",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h60, 0, 6, 0);
    step("rol8_7",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'hC0, 0, 7, 0);
    step("rol8_8",  1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h81, 1, 8, 1);
    step("rol8sat", 1, 0, 1, MODE_ROT,   DIR_LEFT,  0, 8'h00, 8'h03, 1, 8, 1);
    step("ld8clr",  1, 0, 1, MODE_LOAD,  DIR_LEFT,  0, 8'hF0, 8'hF0, 1, 0, 0);
    step("asr8",    1, 0, 1, MODE_ASH,   DIR_RIGHT, 0, 8'h00, 8'hF8, 0, 1, 0);

    if (sb_q.size() != 0) check_value("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
